demux_scan_sequencer: RTL
=========================

// Module: demux_scan_sequencer
// PURPOSE
//  Upstream driver for the 8-way demux (1x2 tree, s[2:0] select).
//  Steps the select through channels 0..7, holding each for a programmable dwell.
//  Gates a serial data bit onto the demux input while scanning.
//  Supports single-sweep and continuous modes, with a sweep-done pulse and sweep counter.
// PARAMETERS
//  DWELL_W   8   width of dwell setting; each channel held dwell+1 cycles
//  SWEEP_W   8   width of completed-sweep counter (wraps)
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         asynchronous, active-high reset
//  start       in   1         1-cycle request to begin a sweep (ignored when busy)
//  stop        in   1         abort; return to IDLE at next edge
//  cont        in   1         1 = restart at ch0 after ch7 (continuous); sampled at each sweep end
//  dwell       in   DWELL_W   hold count per channel; latched on accepted start
//  data_in     in   1         serial bit to route
//  ch_mask     in   8         channel enable mask (only with SCAN_SKIP_MASK_EN)
//  sel         out  3         demux select s[2:0], registered
//  dmx_in      out  1         demux input, registered: data_in when ACTIVE, else 0
//  busy        out  1         1 while ACTIVE
//  sweep_done  out  1         1-cycle pulse on completion of the ch7 (last enabled) dwell
//  sweep_cnt   out  SWEEP_W   completed sweeps since reset, wraps to 0
// BEHAVIOUR
//  Reset (async, any state): IDLE; sel=0, dmx_in=0, busy=0, sweep_done=0, sweep_cnt=0, dwell latch=0.
//  States: IDLE, ACTIVE. All outputs registered; sel and dmx_in update on the same edge.
//  IDLE -> ACTIVE: start=1 and stop=0. On that edge:
//   - latch dwell; sel=first channel (0); dwell counter=0; busy=1.
//   - dmx_in = data_in sampled at that edge.
//  ACTIVE, each cycle: dmx_in <= data_in (1-cycle latency), dwell counter +1.
//  Channel change: when counter==dwell_latched, sel advances to the next channel and counter clears.
//   - Result: each channel is on sel for exactly dwell+1 cycles; dwell=0 gives 1 cycle/channel.
//   - dwell = all-ones gives 2^DWELL_W cycles/channel; no overflow.
//  Last channel expiry:
//   - sweep_done=1 for one cycle, sweep_cnt+1 (2^SWEEP_W-1 wraps to 0).
//   - cont=1: sel=0, stay ACTIVE, no gap cycle.
//   - cont=0: IDLE; sel=0, dmx_in=0, busy=0 on that same edge.
//  stop=1 in ACTIVE: next edge -> IDLE, sel=0, dmx_in=0, busy=0.
//   - No sweep_done and no sweep_cnt change, even on the last channel's final cycle (stop wins).
//  start while ACTIVE is ignored, and is not queued.
//  start and stop together in IDLE: stop wins, stay IDLE.
//  dwell changes while ACTIVE have no effect until the next accepted start.
//  IDLE hold: data_in is never propagated; dmx_in stays 0, so all demux outputs stay 0.
// CONFIGURATION
//  SCAN_SKIP_MASK_EN defined:
//   - ch_mask port exists and is latched on accepted start.
//   - Channels with mask bit 0 are skipped with zero cycles spent; sel walks enabled channels ascending.
//   - "Last channel" = highest enabled bit.
//   - start with ch_mask==0 is ignored (stay IDLE).
//   - A single enabled channel with cont=1 holds that sel indefinitely, pulsing sweep_done every dwell+1 cycles.
//  SCAN_SKIP_MASK_EN undefined: no ch_mask port; all 8 channels visited in order 0..7.
// TESTING
//  1. rst pulse mid-sweep (sel=5) -> all outputs 0 asynchronously, before the next clk edge.
//  2. dwell=2, cont=0, start -> sel 0..7 each 3 cycles (24 cycles); sweep_done at end; sweep_cnt=1; busy falls same edge.
//  3. dwell=0, cont=1, data_in=1 -> sel 0,1,..7,0,1..; dmx_in=1; sweep_done every 8 cycles; sweep_cnt wraps 255->0.
//  4. stop asserted on final cycle of ch7 -> IDLE, sweep_done stays 0, sweep_cnt unchanged; start+stop in IDLE -> stays IDLE.
//  5. start pulsed while busy, and dwell changed mid-sweep -> sweep timing unchanged.
//  6. (SCAN_SKIP_MASK_EN) ch_mask=8'b1010_0100, dwell=1 -> sel 2,2,5,5,7,7, sweep_done after ch7; ch_mask=0 start -> busy stays 0.

Source files
------------

// File: rtl/demux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// demux_scan_sequencer
//
// Purpose:
//   Upstream driver for an 8-way demux (1x2 tree, select s[2:0]). It steps the
//   select through channels 0..7 and holds each one for a programmable dwell
//   (dwell+1 cycles). While scanning, it gates a serial data bit onto the demux
//   input. It supports single-sweep and continuous modes. A one-cycle pulse
//   marks the end of each sweep, and a wrapping counter tracks completed sweeps.
//
// Optional feature:
//   SCAN_SKIP_MASK_EN - when defined, adds the i_ch_mask port. Channels whose
//   mask bit is 0 are skipped, and the last channel becomes the highest
//   enabled channel.
//
// Ports:
//   i_clk        in   1        rising-edge clock
//   i_rst        in   1        asynchronous, active-high reset
//   i_start      in   1        1-cycle sweep request, ignored while busy
//   i_stop       in   1        abort, return to IDLE at next edge
//   i_cont       in   1        continuous mode, sampled at each sweep end
//   i_dwell      in   DWELL_W  hold count per channel, latched on start
//   i_data_in    in   1        serial bit to route
//   i_ch_mask    in   8        channel enable mask (SCAN_SKIP_MASK_EN only)
//   o_sel        out  3        demux select, registered
//   o_dmx_in     out  1        demux input, registered
//   o_busy       out  1        high while ACTIVE
//   o_sweep_done out  1        1-cycle pulse at end of a sweep
//   o_sweep_cnt  out  SWEEP_W  completed sweeps, wraps to 0
// ---------------------------------------------------------------------------
module demux_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int SWEEP_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_cont,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_data_in,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [7:0]         i_ch_mask,
`endif
    output logic [2:0]         o_sel,
    output logic               o_dmx_in,
    output logic               o_busy,
    output logic               o_sweep_done,
    output logic [SWEEP_W-1:0] o_sweep_cnt
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [2:0]         r_sel;
    logic [2:0]         w_selNext;
    logic               r_dmx;
    logic               w_dmxNext;
    logic               r_done;
    logic               w_doneNext;
    logic [SWEEP_W-1:0] r_sweepCnt;
    logic [SWEEP_W-1:0] w_sweepCntNext;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwellNext;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cntNext;
    logic [7:0]         w_startMask;
    logic [7:0]         w_activeMask;

`ifdef SCAN_SKIP_MASK_EN
    logic [7:0]         r_mask;
    logic [7:0]         w_maskNext;

    assign w_startMask  = i_ch_mask;
    assign w_activeMask = r_mask;
`else
    assign w_startMask  = 8'hFF;
    assign w_activeMask = 8'hFF;
`endif

    // Lowest enabled channel: where a sweep begins.
    function automatic logic [2:0] firstCh(input logic [7:0] mask);
        logic [2:0] f;
        f = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) f = 3'(i);
        end
        return f;
    endfunction

    // Highest enabled channel: its expiry ends the sweep.
    function automatic logic [2:0] lastCh(input logic [7:0] mask);
        logic [2:0] f;
        f = 3'd0;
        for (int i = 0; i <= 7; i++) begin
            if (mask[i]) f = 3'(i);
        end
        return f;
    endfunction

    // Next enabled channel above cur. Disabled channels cost no cycles.
    function automatic logic [2:0] nextCh(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] f;
        f = cur;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) f = 3'(i);
        end
        return f;
    endfunction

    // State and output registers. Every output comes straight from a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_sel      <= 3'd0;
            r_dmx      <= 1'b0;
            r_done     <= 1'b0;
            r_sweepCnt <= '0;
            r_dwell    <= '0;
            r_cnt      <= '0;
`ifdef SCAN_SKIP_MASK_EN
            r_mask     <= 8'h00;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_sel      <= w_selNext;
            r_dmx      <= w_dmxNext;
            r_done     <= w_doneNext;
            r_sweepCnt <= w_sweepCntNext;
            r_dwell    <= w_dwellNext;
            r_cnt      <= w_cntNext;
`ifdef SCAN_SKIP_MASK_EN
            r_mask     <= w_maskNext;
`endif
        end
    end

    // Next-state logic. Stop always beats channel expiry, so an aborted
    // sweep never reports done or bumps the counter.
    always_comb begin
        w_stateNext    = r_state;
        w_selNext      = r_sel;
        w_dmxNext      = 1'b0;
        w_doneNext     = 1'b0;
        w_sweepCntNext = r_sweepCnt;
        w_dwellNext    = r_dwell;
        w_cntNext      = r_cnt;
`ifdef SCAN_SKIP_MASK_EN
        w_maskNext     = r_mask;
`endif
        case (r_state)
            IDLE: begin
                w_selNext = 3'd0;
                w_cntNext = '0;
                if (i_start && !i_stop && (|w_startMask)) begin
                    w_stateNext = ACTIVE;
                    w_dwellNext = i_dwell;
                    w_selNext   = firstCh(w_startMask);
                    w_dmxNext   = i_data_in;
`ifdef SCAN_SKIP_MASK_EN
                    w_maskNext  = i_ch_mask;
`endif
                end
            end
            ACTIVE: begin
                if (i_stop) begin
                    w_stateNext = IDLE;
                    w_selNext   = 3'd0;
                    w_cntNext   = '0;
                end else begin
                    w_dmxNext = i_data_in;
                    if (r_cnt == r_dwell) begin
                        w_cntNext = '0;
                        if (r_sel == lastCh(w_activeMask)) begin
                            w_doneNext     = 1'b1;
                            w_sweepCntNext = r_sweepCnt + SWEEP_W'(1);
                            if (i_cont) begin
                                w_selNext = firstCh(w_activeMask);
                            end else begin
                                w_stateNext = IDLE;
                                w_selNext   = 3'd0;
                                w_dmxNext   = 1'b0;
                            end
                        end else begin
                            w_selNext = nextCh(r_sel, w_activeMask);
                        end
                    end else begin
                        w_cntNext = r_cnt + DWELL_W'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_selNext   = 3'd0;
            end
        endcase
    end

    assign o_sel        = r_sel;
    assign o_dmx_in     = r_dmx;
    assign o_busy       = (r_state == ACTIVE);
    assign o_sweep_done = r_done;
    assign o_sweep_cnt  = r_sweepCnt;

endmodule
